// File: rtl/pc_pkg.sv
// Shared definitions for the fetch PC / redirect slice.
//   WORD_SIZE   : default PC/address width
//   PC_MAX_W    : storage width of a pipeline entry target (any WIDTH up to this)
//   INSTR_ALIGN : minimum instruction alignment in bytes (jalr targets honour it)
//   ctl_entry_t : one alignment-pipeline entry {valid, is_branch, is_jalr, target}
package pc_pkg;

  localparam int unsigned WORD_SIZE   = 32;
  localparam int unsigned PC_MAX_W    = 64;
  localparam int unsigned INSTR_ALIGN = 2;

  typedef struct packed {
    logic                valid;
    logic                is_branch;
    logic                is_jalr;
    logic [PC_MAX_W-1:0] target;
  } ctl_entry_t;

endpackage

// File: rtl/branch_align_pipe.sv
// Alignment shift register carrying decoded control entries to ALU resolution.
//   clk, rst_n : clock, asynchronous active-low reset
//   shift_en   : advance one stage (stage 1 captures in_entry)
//   flush      : synchronous clear of every stage, wins over shift_en
//   in_entry   : entry presented by decode
//   head       : oldest stage (stage DEPTH)
module branch_align_pipe
  import pc_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       shift_en,
  input  logic       flush,
  input  ctl_entry_t in_entry,
  output ctl_entry_t head
);

  ctl_entry_t stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else if (shift_en) begin
      stage[0] <= in_entry;
      for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign head = stage[DEPTH-1];

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch PC generator with branch/jalr redirect and redirect counter.
//   clk, reset_n   : clock, asynchronous active-low reset
//   stall          : freeze PC, alignment pipeline and counter
//   dec_valid, dec_branch, dec_jalr, dec_target : decode-stage control info
//   alu_taken      : resolution for the entry at the pipeline head
//   alu_target     : jalr target from the ALU
//   pc             : registered fetch PC
//   redirect       : registered one-cycle pulse, pc holds a redirect target
//   redirect_count : saturating number of redirects
module pc_redirect_unit
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH      = WORD_SIZE,
  parameter int unsigned      BRANCH_LAT = 2,
  parameter int unsigned      STEP       = 4,
  parameter logic [WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned      CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall,
  input  logic             dec_valid,
  input  logic             dec_branch,
  input  logic             dec_jalr,
  input  logic [WIDTH-1:0] dec_target,
  input  logic             alu_taken,
  input  logic [WIDTH-1:0] alu_target,
  output logic [WIDTH-1:0] pc,
  output logic             redirect,
  output logic [CNT_W-1:0] redirect_count
);

  ctl_entry_t       cap_entry;
  ctl_entry_t       head;
  logic             take_br;
  logic             take_jr;
  logic             take;
  logic [WIDTH-1:0] next_pc;
  logic             unused_bits;

  always_comb begin
    cap_entry           = '0;
    cap_entry.valid     = dec_valid & (dec_branch | dec_jalr);
    cap_entry.is_branch = dec_branch;
    cap_entry.is_jalr   = dec_jalr;
    cap_entry.target    = PC_MAX_W'(dec_target);
  end

  // Taking a redirect flushes the whole pipe on the same edge, so the
  // capture of that cycle is dropped along with the younger entries.
  branch_align_pipe #(
    .DEPTH (BRANCH_LAT)
  ) u_pipe (
    .clk      (clk),
    .rst_n    (reset_n),
    .shift_en (~stall),
    .flush    (take),
    .in_entry (cap_entry),
    .head     (head)
  );

  always_comb begin
    take_br = ~stall & head.valid & head.is_branch & alu_taken;
    take_jr = ~stall & head.valid & head.is_jalr & ~head.is_branch & alu_taken;
    take    = take_br | take_jr;
    if (take_br)      next_pc = head.target[WIDTH-1:0];
    else if (take_jr) next_pc = alu_target & ~WIDTH'(INSTR_ALIGN - 1);
    else              next_pc = pc + WIDTH'(STEP);
  end

  always_comb unused_bits = ^{head.target, alu_target[0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc             <= RESET_PC;
      redirect       <= 1'b0;
      redirect_count <= '0;
    end else begin
      redirect <= take;
      if (!stall) pc <= next_pc;
      if (take && redirect_count != '1) redirect_count <= redirect_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pc_redirect_unit.sv
module tb_pc_redirect_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall;
  logic        dec_valid;
  logic        dec_branch;
  logic        dec_jalr;
  logic [31:0] dec_target;
  logic        alu_taken;
  logic [31:0] alu_target;

  logic [31:0] pc_a;
  logic        red_a;
  logic [15:0] cnt_a;
  logic [7:0]  pc_b;
  logic        red_b;
  logic [1:0]  cnt_b;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  pc_redirect_unit #(
    .WIDTH      (32),
    .BRANCH_LAT (2),
    .STEP       (4),
    .RESET_PC   (32'h100),
    .CNT_W      (16)
  ) dut_a (
    .clk            (clk),
    .reset_n        (reset_n),
    .stall          (stall),
    .dec_valid      (dec_valid),
    .dec_branch     (dec_branch),
    .dec_jalr       (dec_jalr),
    .dec_target     (dec_target),
    .alu_taken      (alu_taken),
    .alu_target     (alu_target),
    .pc             (pc_a),
    .redirect       (red_a),
    .redirect_count (cnt_a)
  );

  pc_redirect_unit #(
    .WIDTH      (8),
    .BRANCH_LAT (3),
    .STEP       (4),
    .RESET_PC   (8'hFC),
    .CNT_W      (2)
  ) dut_b (
    .clk            (clk),
    .reset_n        (reset_n),
    .stall          (stall),
    .dec_valid      (dec_valid),
    .dec_branch     (dec_branch),
    .dec_jalr       (dec_jalr),
    .dec_target     (dec_target[7:0]),
    .alu_taken      (alu_taken),
    .alu_target     (alu_target[7:0]),
    .pc             (pc_b),
    .redirect       (red_b),
    .redirect_count (cnt_b)
  );

  // Reference model: a list of in-flight control ops stamped with the
  // unstalled-edge count at capture; an op is resolvable once BRANCH_LAT-1
  // further unstalled edges have passed.
  typedef struct {
    int              inst;
    bit              br;
    bit              jr;
    longint unsigned tgt;
    longint unsigned tcap;
  } ment_t;

  ment_t           mq[$];
  longint unsigned m_pc  [2];
  longint unsigned m_cnt [2];
  bit              m_red [2];
  longint unsigned ucnt;

  function automatic int bl(int k);
    return (k == 0) ? 2 : 3;
  endfunction

  function automatic longint unsigned pmask(int k);
    return (k == 0) ? 64'hFFFF_FFFF : 64'hFF;
  endfunction

  function automatic longint unsigned rstpc(int k);
    return (k == 0) ? 64'h100 : 64'hFC;
  endfunction

  function automatic longint unsigned cmax(int k);
    return (k == 0) ? 64'd65535 : 64'd3;
  endfunction

  task automatic model_reset();
    mq.delete();
    for (int k = 0; k < 2; k++) begin
      m_pc[k]  = rstpc(k);
      m_cnt[k] = 0;
      m_red[k] = 1'b0;
    end
    ucnt = 0;
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int hi;
      bit take;
      longint unsigned tgt;
      hi = -1;
      for (int i = 0; i < mq.size(); i++)
        if (mq[i].inst == k && ucnt - mq[i].tcap == longint'(bl(k) - 1)) hi = i;
      if (stall) begin
        m_red[k] = 1'b0;
      end else begin
        take = 1'b0;
        tgt  = 0;
        if (hi >= 0 && alu_taken) begin
          if (mq[hi].br) begin
            take = 1'b1;
            tgt  = mq[hi].tgt;
          end else if (mq[hi].jr) begin
            take = 1'b1;
            tgt  = longint'(alu_target) & pmask(k) & ~64'd1;
          end
        end
        if (take) begin
          m_pc[k]  = tgt;
          m_red[k] = 1'b1;
          if (m_cnt[k] < cmax(k)) m_cnt[k]++;
          for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].inst == k) mq.delete(i);
        end else begin
          m_pc[k]  = (m_pc[k] + 4) & pmask(k);
          m_red[k] = 1'b0;
          if (hi >= 0) mq.delete(hi);
          if (dec_valid && (dec_branch || dec_jalr)) begin
            ment_t e;
            e.inst = k;
            e.br   = dec_branch;
            e.jr   = dec_jalr;
            e.tgt  = longint'(dec_target) & pmask(k);
            e.tcap = ucnt + 1;
            mq.push_back(e);
          end
        end
      end
    end
    if (!stall) ucnt++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("pc_a",  {32'd0, pc_a},  m_pc[0]);
    chk("red_a", {63'd0, red_a}, {63'd0, m_red[0]});
    chk("cnt_a", {48'd0, cnt_a}, m_cnt[0]);
    chk("pc_b",  {56'd0, pc_b},  m_pc[1]);
    chk("red_b", {63'd0, red_b}, {63'd0, m_red[1]});
    chk("cnt_b", {62'd0, cnt_b}, m_cnt[1]);
  endtask

  task automatic drive(input bit st, input bit v, input bit br, input bit jr,
                       input logic [31:0] dt, input logic [31:0] at, input bit tk);
    stall      = st;
    dec_valid  = v;
    dec_branch = br;
    dec_jalr   = jr;
    dec_target = dt;
    alu_target = at;
    alu_taken  = tk;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 32'h0, 32'h0, 0);
      step();
    end
  endtask

  initial begin
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 32'h0, 32'h0, 0);
    #12;
    model_reset();
    check_all();
    chk("rst_pc_a", {32'd0, pc_a}, 64'h100);
    chk("rst_pc_b", {56'd0, pc_b}, 64'hFC);
    reset_n = 1'b1;

    // sequential advance and 8-bit wrap
    step();
    chk("seq0_a", {32'd0, pc_a}, 64'h104);
    chk("wrap_b", {56'd0, pc_b}, 64'h00);
    step();
    chk("seq1_a", {32'd0, pc_a}, 64'h108);
    idle(2);

    // taken branch
    drive(0, 1, 1, 0, 32'h200, 32'h0, 0); step();
    idle(1);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 1); step();
    chk("br_pc", {32'd0, pc_a}, 64'h200);
    chk("br_red", {63'd0, red_a}, 64'd1);
    chk("br_cnt", {48'd0, cnt_a}, 64'd1);
    idle(1);
    chk("br_pulse", {63'd0, red_a}, 64'd0);
    chk("br_after", {32'd0, pc_a}, 64'h204);
    idle(3);

    // not taken
    drive(0, 1, 1, 0, 32'h200, 32'h0, 0); step();
    idle(1);
    idle(1);
    chk("nt_red", {63'd0, red_a}, 64'd0);
    idle(3);

    // jalr
    drive(0, 1, 0, 1, 32'h0, 32'h0, 0); step();
    idle(1);
    drive(0, 0, 0, 0, 32'h0, 32'h3F3, 1); step();
    chk("jr_pc", {32'd0, pc_a}, 64'h3F2);
    idle(3);

    // both flags: branch wins
    drive(0, 1, 1, 1, 32'h500, 32'h0, 0); step();
    idle(1);
    drive(0, 0, 0, 0, 32'h0, 32'h600, 1); step();
    chk("both_pc", {32'd0, pc_a}, 64'h500);
    idle(3);

    // squash of a younger entry
    drive(0, 1, 1, 0, 32'h200, 32'h0, 0); step();
    drive(0, 1, 1, 0, 32'h900, 32'h0, 0); step();
    drive(0, 0, 0, 0, 32'h0, 32'h0, 1); step();
    chk("sq_pc", {32'd0, pc_a}, 64'h200);
    step();
    chk("sq_red", {63'd0, red_a}, 64'd0);
    chk("sq_pc2", {32'd0, pc_a}, 64'h204);
    chk("sq_cnt", {48'd0, cnt_a}, 64'd4);
    idle(4);

    // stall with a branch mid-pipeline
    drive(0, 1, 1, 0, 32'h700, 32'h0, 0); step();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 0, 32'h123, 32'h0, 1); step();
      chk("stall_red", {63'd0, red_a}, 64'd0);
    end
    idle(1);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 1); step();
    chk("stall_pc", {32'd0, pc_a}, 64'h700);
    chk("stall_red1", {63'd0, red_a}, 64'd1);
    idle(4);

    // counter saturation
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 1, 0, 32'h40, 32'h0, 1); step();
    end
    chk("sat_b", {62'd0, cnt_b}, 64'd3);
    idle(4);

    // reset mid-pipeline
    drive(0, 1, 1, 0, 32'h300, 32'h0, 0); step();
    drive(0, 0, 0, 0, 32'h0, 32'h0, 1);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("mrst_pc_a", {32'd0, pc_a}, 64'h100);
    chk("mrst_cnt_a", {48'd0, cnt_a}, 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mrst_red_a", {63'd0, red_a}, 64'd0);
      chk("mrst_red_b", {63'd0, red_b}, 64'd0);
    end

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(7) == 0, $urandom_range(3) != 0, 1'($urandom),
            1'($urandom), $urandom, $urandom, 1'($urandom));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/pc_redirect_unit.md
# pc_redirect_unit

Parametrised program-counter generator and redirect unit for the pipelined core. It owns the fetch PC register and advances it sequentially. It carries each decoded branch/jalr through a BRANCH_LAT-deep alignment pipeline so that it meets its late ALU resolution. On a taken resolution it redirects fetch and squashes the younger in-flight control entries. It sits between decode/ALU and instruction fetch, and provides a saturating redirect counter for performance monitoring.

## Interface
Parameters:
- WIDTH, 32, PC/address width in bits
- BRANCH_LAT, 2, cycles from decode capture to ALU resolution; legal range 1..8
- STEP, 4, sequential PC increment
- RESET_PC, 0, PC value loaded on reset
- CNT_W, 16, redirect counter width

Ports:
- clk  in  1  single clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- stall  in  1  freeze PC, alignment pipeline and counter
- dec_valid  in  1  decode-stage instruction valid
- dec_branch  in  1  decoded conditional branch
- dec_jalr  in  1  decoded jalr
- dec_target  in  WIDTH  branch target computed at decode
- alu_taken  in  1  resolution for the entry at pipeline head
- alu_target  in  WIDTH  jalr target computed by the ALU
- pc  out  WIDTH  current fetch PC (registered)
- redirect  out  1  one-cycle pulse, registered; pc holds a redirect target this cycle
- redirect_count  out  CNT_W  saturating count of redirects

## Operation
- Alignment pipeline: BRANCH_LAT entries, each {valid, is_branch, is_jalr, target}. Stage 1 captures the decode inputs when stall=0. valid is set only if dec_valid & (dec_branch | dec_jalr). Entries shift one stage per unstalled cycle. The head is stage BRANCH_LAT.
- Resolution is evaluated combinationally on the head entry, and only when stall=0:
  - take_br = head.valid & head.is_branch & alu_taken
  - take_jr = head.valid & head.is_jalr & ~head.is_branch & alu_taken. Branch wins if both flags are set.
- Next PC:
  - take_br: head.target
  - else take_jr: {alu_target[WIDTH-1:1], 1'b0}
  - else: pc + STEP, truncated mod 2^WIDTH (wraps to 0 silently)
- On take_br or take_jr:
  - All pipeline entries are cleared on that edge, including stage 1; the decode capture that cycle is discarded (squashed).
  - redirect <= 1.
  - redirect_count increments, saturating at 2^CNT_W-1.
- Otherwise redirect <= 0.
- alu_taken with a non-valid head is ignored, with no redirect.
- stall=1: pc, pipeline, redirect_count hold. alu_taken and dec_* are ignored. redirect <= 0, so a pulse never stretches across a stall.

## Timing
- Reset (async assert, sync release): pc=RESET_PC, all entries invalid, redirect=0, redirect_count=0. Reset mid-operation discards all in-flight entries.
- Decode captured at edge E0 reaches the head after BRANCH_LAT-1 further unstalled edges. It is resolved in the cycle following that edge, i.e. alu_taken is sampled BRANCH_LAT unstalled cycles after capture.
- Redirect latency: on the resolving edge pc takes the target and redirect=1, both visible for exactly one cycle before normal sequencing resumes.
- Back-to-back: a resolution in the cycle right after a redirect sees an empty head, so no second redirect is possible.
- Stall cycles stretch latency one-for-one.

## Structure
- Shared package pc_pkg:
  - WORD_SIZE default
  - typedef ctl_entry_t {valid, is_branch, is_jalr, target}
  - localparam for minimum instruction alignment
- Sub-module branch_align_pipe: parametrised shift register of ctl_entry_t with shift-enable (~stall) and synchronous clear (redirect), exposing the head entry.
- Top contains the next-PC select, PC register, redirect register and saturating counter.

## Test plan
- Reset/sequential, WIDTH=32, STEP=4, RESET_PC=0x100: release reset, no stalls → pc 0x100, 0x104, 0x108; redirect=0, redirect_count=0.
- Taken branch, BRANCH_LAT=2: capture dec_branch, dec_target=0x200 at edge E0; drive alu_taken=1 two cycles later → pc=0x200 with redirect=1 for one cycle, redirect_count=1; same stimulus with alu_taken=0 → pc continues +4.
- jalr, both flags set: dec_jalr with alu_target=0x3F3 → pc=0x3F2. Then an entry with dec_branch=dec_jalr=1, dec_target=0x500, alu_target=0x600 → pc=0x500.
- Squash: branch at E0, second branch at E1 (target 0x900); first resolves taken to 0x200 → second entry never redirects even with alu_taken held high; redirect_count=1.
- Stall: assert stall for 3 cycles while a branch is mid-pipeline, with alu_taken=1 during the stall → pc frozen, no redirect. Resolution occurs 3 cycles later than unstalled.
- Wrap/saturation/reset, WIDTH=8, RESET_PC=0xFC, CNT_W=2: pc wraps 0xFC→0x00. Four redirects → count holds at 3. reset_n low mid-pipeline → outputs return to reset values immediately, and no redirect follows release.
